mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes non-memory ops straight through and runs LOAD/STORE accesses with a timeout.
// Latency: 0 cycles for pass-through ops, at least 3 cycles (IDLE->ACCESS->DONE) for memory ops.
// Backpressure: stall_o is high from acceptance until DONE; upstream holds its inputs stable meanwhile.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  Op_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rsd_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] memory_data_o,
  output logic [4:0]  rsd_o,
  output logic [2:0]  Op_o,
  output logic        valid_o,
  output logic        err_o
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic is_mem_op;
  logic aligned;

  assign is_mem_op = (Op_i == OP_LOAD) || (Op_i == OP_STORE);
  assign aligned   = (alu_result_i[1:0] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = 32'd0;
    mem_wdata_o   = 32'd0;
    stall_o       = 1'b0;
    valid_o       = 1'b0;
    Op_o          = Op_i;
    alu_result_o  = alu_result_i;
    rsd_o         = rsd_i;
    memory_data_o = 32'd0;

    case (state_q)
      ST_IDLE: begin
        valid_o = valid_i;
        if (valid_i && is_mem_op) begin
          if (aligned) begin
            stall_o = 1'b1;
            valid_o = 1'b0;
            cnt_d   = 8'd0;
            state_d = ST_ACCESS;
          end else begin
            // Misaligned access is squashed into a NOP and flagged.
            Op_o  = OP_NOP;
            err_d = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = (Op_i == OP_STORE);
        mem_addr_o  = alu_result_i;
        mem_wdata_o = store_data_i;
        stall_o     = 1'b1;
        cnt_d       = cnt_q + 8'd1;
        if (mem_ack_i) begin
          rdata_d = (Op_i == OP_LOAD) ? mem_rdata_i : 32'd0;
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        valid_o       = 1'b1;
        memory_data_o = rdata_q;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset masks every output so nothing leaks to MEM/WB or memory while held.
    if (rst_i) begin
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = 32'd0;
      mem_wdata_o   = 32'd0;
      stall_o       = 1'b0;
      valid_o       = 1'b0;
      Op_o          = 3'd0;
      alu_result_o  = 32'd0;
      rsd_o         = 5'd0;
      memory_data_o = 32'd0;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table-driven pass-through vectors, directed memory sequences, and a
// scoreboard queue that checks every valid_o beat against the expected MEM/WB record.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  Op_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [4:0]  rsd_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        stall_o;
  logic [31:0] alu_result_o;
  logic [31:0] memory_data_o;
  logic [4:0]  rsd_o;
  logic [2:0]  Op_o;
  logic        valid_o;
  logic        err_o;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rsd_i(rsd_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .stall_o(stall_o), .alu_result_o(alu_result_o),
    .memory_data_o(memory_data_o), .rsd_o(rsd_o), .Op_o(Op_o),
    .valid_o(valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] alu;
    logic [4:0]  rsd;
    logic [31:0] mdata;
  } exp_t;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [4:0]  rsd;
    logic        exp_v;
    logic [2:0]  exp_op;
    logic        exp_stall;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid_o beat must match the oldest pending expectation.
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_op", 32'(Op_o), 32'(e.op));
        chk("sb_alu", alu_result_o, e.alu);
        chk("sb_rsd", 32'(rsd_o), 32'(e.rsd));
        chk("sb_mdata", memory_data_o, e.mdata);
      end
    end
  end

  // Issue one aligned LOAD/STORE; ack_at is the 1-based ACCESS cycle that acks (0 = never).
  task automatic mem_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rsd, input int ack_at, input logic [31:0] rd,
                        input logic [31:0] exp_md, input int exp_req);
    exp_t e;
    int   n_req = 0;
    bit   done  = 0;
    valid_i = 1'b1; Op_i = op; alu_result_i = addr; store_data_i = wd; rsd_i = rsd;
    mem_ack_i = 1'b0;
    e.op = op; e.alu = addr; e.rsd = rsd; e.mdata = exp_md;
    exp_q.push_back(e);
    @(negedge clk);
    chk("idle_stall", 32'(stall_o), 32'd1);
    chk("idle_no_req", 32'(mem_req_o), 32'd0);
    step();
    for (int i = 1; i <= 40; i++) begin
      mem_ack_i   = (i == ack_at);
      mem_rdata_i = (i == ack_at) ? rd : (32'hA5A5_0000 | 32'(i));
      @(negedge clk);
      if (!mem_req_o) begin
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_valid", 32'(valid_o), 32'd1);
        chk("done_mdata", memory_data_o, exp_md);
        chk("done_addr_zero", mem_addr_o, 32'd0);
        chk("done_wdata_zero", mem_wdata_o, 32'd0);
        chk("done_we_zero", 32'(mem_we_o), 32'd0);
        done = 1;
        break;
      end
      n_req++;
      chk("acc_addr", mem_addr_o, addr);
      chk("acc_we", 32'(mem_we_o), 32'(op == 3'b011));
      chk("acc_wdata", mem_wdata_o, wd);
      chk("acc_stall", 32'(stall_o), 32'd1);
      step();
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("req_cycles", 32'(n_req), 32'(exp_req));
    step();
    valid_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    vecs[0] = '{1'b1, 3'b001, 32'h0000_0010, 5'd5,  1'b1, 3'b001, 1'b0};
    vecs[1] = '{1'b1, 3'b000, 32'hFFFF_FFFF, 5'd0,  1'b1, 3'b000, 1'b0};
    vecs[2] = '{1'b0, 3'b010, 32'h0000_0100, 5'd3,  1'b0, 3'b010, 1'b0};
    vecs[3] = '{1'b0, 3'b011, 32'h0000_0044, 5'd3,  1'b0, 3'b011, 1'b0};
    vecs[4] = '{1'b1, 3'b100, 32'h8000_0001, 5'd31, 1'b1, 3'b100, 1'b0};
    vecs[5] = '{1'b1, 3'b111, 32'h0000_0003, 5'd9,  1'b1, 3'b111, 1'b0};
    vecs[6] = '{1'b1, 3'b001, 32'h1234_5678, 5'd1,  1'b1, 3'b001, 1'b0};

    // Reset with a live ALU op on the inputs: outputs must stay masked.
    rst_i = 1'b1; valid_i = 1'b1; Op_i = 3'b001; alu_result_i = 32'h10; rsd_i = 5'd5;
    store_data_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    step(); step();
    @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_alu", alu_result_o, 32'd0);
    chk("rst_rsd", 32'(rsd_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    step();
    rst_i = 1'b0; valid_i = 1'b0;

    foreach (vecs[k]) begin
      valid_i = vecs[k].v; Op_i = vecs[k].op; alu_result_i = vecs[k].alu; rsd_i = vecs[k].rsd;
      if (vecs[k].exp_v) begin
        e.op = vecs[k].exp_op; e.alu = vecs[k].alu; e.rsd = vecs[k].rsd; e.mdata = 32'd0;
        exp_q.push_back(e);
      end
      @(negedge clk);
      chk("vec_valid", 32'(valid_o), 32'(vecs[k].exp_v));
      chk("vec_stall", 32'(stall_o), 32'(vecs[k].exp_stall));
      chk("vec_req", 32'(mem_req_o), 32'd0);
      step();
    end
    valid_i = 1'b0;

    mem_op(3'b010, 32'h0000_0100, 32'd0, 5'd7, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
    mem_op(3'b011, 32'h0000_0040, 32'h1234, 5'd8, 1, 32'hFFFF_FFFF, 32'd0, 1);
    mem_op(3'b010, 32'h0000_01FC, 32'd0, 5'd2, 5, 32'h0BAD_F00D, 32'h0BAD_F00D, 5);
    chk("err_clear_after_ok", 32'(err_o), 32'd0);

    // Misaligned LOAD becomes a NOP beat, error appears on the next cycle.
    valid_i = 1'b1; Op_i = 3'b010; alu_result_i = 32'h102; rsd_i = 5'd4;
    e.op = 3'b000; e.alu = 32'h102; e.rsd = 5'd4; e.mdata = 32'd0;
    exp_q.push_back(e);
    @(negedge clk);
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_req", 32'(mem_req_o), 32'd0);
    chk("mis_err_not_yet", 32'(err_o), 32'd0);
    step();
    valid_i = 1'b0;
    @(negedge clk);
    chk("mis_err_set", 32'(err_o), 32'd1);
    step();

    // Only reset clears the sticky error.
    rst_i = 1'b1; step(); rst_i = 1'b0;
    @(negedge clk);
    chk("err_reset", 32'(err_o), 32'd0);
    step();

    // Timeout: 16 request cycles, a late ack in DONE must be ignored.
    mem_op(3'b010, 32'h0000_0300, 32'd0, 5'd12, 17, 32'hCAFE_CAFE, 32'd0, 16);
    chk("tmo_err", 32'(err_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    @(negedge clk);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    chk("late_ack_valid", 32'(valid_o), 32'd0);
    step();
    mem_ack_i = 1'b0;

    // A second error keeps the flag set.
    valid_i = 1'b1; Op_i = 3'b011; alu_result_i = 32'h41; rsd_i = 5'd6;
    e.op = 3'b000; e.alu = 32'h41; e.rsd = 5'd6; e.mdata = 32'd0;
    exp_q.push_back(e);
    step();
    valid_i = 1'b0;
    @(negedge clk);
    chk("err_sticky", 32'(err_o), 32'd1);
    step();

    // Reset in the 2nd ACCESS cycle aborts the LOAD with no DONE beat.
    valid_i = 1'b1; Op_i = 3'b010; alu_result_i = 32'h200; rsd_i = 5'd10;
    step();
    @(negedge clk);
    chk("abort_acc1_req", 32'(mem_req_o), 32'd1);
    step();
    rst_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    chk("abort_rst_req", 32'(mem_req_o), 32'd0);
    chk("abort_rst_stall", 32'(stall_o), 32'd0);
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_req", 32'(mem_req_o), 32'd0);
      chk("abort_stall", 32'(stall_o), 32'd0);
      chk("abort_err", 32'(err_o), 32'd0);
      step();
    end

    // Normal operation resumes after the abort.
    mem_op(3'b010, 32'h0000_0204, 32'd0, 5'd11, 1, 32'h5A5A_A5A5, 32'h5A5A_A5A5, 1);
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
